multicycle_controller: RTL and testbench

//   Control FSM for the multi-cycle RISC-V RV32I core: sequences each instruction through

---
 rtl/multicycle_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle RV32I core. Sequences each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared variable-latency memory
// port. A request/ready handshake, a bus-timeout trap and illegal-opcode
// trapping are included. Datapath controls are decoded from the registered
// state and the opcode captured in DECODE. Handshake-qualified strobes
// (ir_wr_en_o, store retirement) follow mem_ready_i in the same cycle, and the
// EXECUTE pc_src_o follows branch_taken_i.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,   // wait cycles before bus-timeout trap; 0 disables
  parameter bit TRAP_HALT   = 1'b1  // 1: trap is terminal, 0: vector and refetch
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_code_i,
  input  logic       mem_ready_i,
  input  logic       branch_taken_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_addr_src_o,
  output logic       ir_wr_en_o,
  output logic       pc_wr_en_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       regf_wr_en_o,
  output logic [1:0] regf_rd_src_o,
  output logic       instr_done_o,
  output logic       trap_o,
  output logic       busy_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // The counter only has to hold values below MEM_TIMEOUT.
  localparam int              CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t           r_state;
  logic [6:0]       r_op;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  // A waiting request expires when this is its last allowed wait cycle and
  // ready is still low; ready in that same cycle takes priority.
  assign w_tmo_hit = TMO_EN && ((r_state == S_FETCH) || (r_state == S_MEM)) &&
                     !mem_ready_i && (r_tmo_cnt == TMO_LAST);

  // State sequencing, opcode capture and memory wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_op      <= 7'd0;
      r_tmo_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state   <= S_FETCH;
          r_tmo_cnt <= '0;
        end
        S_FETCH: begin
          if (mem_ready_i) begin
            r_state   <= S_DECODE;
            r_tmo_cnt <= '0;
          end else if (w_tmo_hit) begin
            r_state   <= S_TRAP;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          r_op      <= op_code_i;
          r_tmo_cnt <= '0;
          r_state   <= is_legal(op_code_i) ? S_EXECUTE : S_TRAP;
        end
        S_EXECUTE: begin
          r_tmo_cnt <= '0;
          if (r_op == OP_BRANCH) begin
            r_state <= S_FETCH;
          end else if ((r_op == OP_LOAD) || (r_op == OP_STORE)) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WRITEBACK;
          end
        end
        S_MEM: begin
          if (mem_ready_i) begin
            r_state   <= (r_op == OP_LOAD) ? S_WRITEBACK : S_FETCH;
            r_tmo_cnt <= '0;
          end else if (w_tmo_hit) begin
            r_state   <= S_TRAP;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
        end
        S_WRITEBACK: begin
          r_state   <= S_FETCH;
          r_tmo_cnt <= '0;
        end
        S_TRAP: begin
          r_tmo_cnt <= '0;
          r_state   <= TRAP_HALT ? S_TRAP : S_FETCH;
        end
        default: begin
          r_state   <= S_IDLE;
          r_tmo_cnt <= '0;
        end
      endcase
    end
  end

  // Datapath control decode from state and captured opcode.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_src_o = 1'b0;
    ir_wr_en_o     = 1'b0;
    pc_wr_en_o     = 1'b0;
    pc_src_o       = 2'b00;
    alu_src_a_o    = 1'b0;
    alu_src_b_o    = 1'b0;
    regf_wr_en_o   = 1'b0;
    regf_rd_src_o  = 2'b00;
    instr_done_o   = 1'b0;
    trap_o         = 1'b0;
    busy_o         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
      end
      S_FETCH: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        ir_wr_en_o = mem_ready_i;
      end
      S_DECODE: begin
        busy_o = 1'b1;
      end
      S_EXECUTE: begin
        busy_o      = 1'b1;
        alu_src_a_o = (r_op == OP_AUIPC) || (r_op == OP_JAL);
        alu_src_b_o = (r_op == OP_IALU) || (r_op == OP_LOAD) || (r_op == OP_STORE) ||
                      (r_op == OP_JALR) || (r_op == OP_AUIPC) || (r_op == OP_JAL);
        if (r_op == OP_BRANCH) begin
          pc_wr_en_o   = 1'b1;
          pc_src_o     = branch_taken_i ? 2'b01 : 2'b00;
          instr_done_o = 1'b1;
        end else begin
          pc_wr_en_o   = 1'b0;
        end
      end
      S_MEM: begin
        busy_o         = 1'b1;
        mem_req_o      = 1'b1;
        mem_addr_src_o = 1'b1;
        mem_we_o       = (r_op == OP_STORE);
        if (mem_ready_i && (r_op == OP_STORE)) begin
          pc_wr_en_o   = 1'b1;
          instr_done_o = 1'b1;
        end else begin
          pc_wr_en_o   = 1'b0;
        end
      end
      S_WRITEBACK: begin
        busy_o       = 1'b1;
        regf_wr_en_o = 1'b1;
        pc_wr_en_o   = 1'b1;
        instr_done_o = 1'b1;
        case (r_op)
          OP_JAL:  pc_src_o = 2'b01;
          OP_JALR: pc_src_o = 2'b10;
          default: pc_src_o = 2'b00;
        endcase
        case (r_op)
          OP_LOAD:          regf_rd_src_o = 2'b01;
          OP_JAL, OP_JALR:  regf_rd_src_o = 2'b10;
          OP_LUI:           regf_rd_src_o = 2'b11;
          default:          regf_rd_src_o = 2'b00;
        endcase
      end
      S_TRAP: begin
        trap_o = 1'b1;
        if (TRAP_HALT) begin
          busy_o = 1'b0;
        end else begin
          busy_o     = 1'b1;
          pc_wr_en_o = 1'b1;
          pc_src_o   = 2'b11;
        end
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Instructions (directed, then
// random) are expanded into a per-cycle schedule of inputs and expected
// outputs straight from the instruction-level rules, then replayed on a
// vectoring DUT (MEM_TIMEOUT=4, TRAP_HALT=0). A second DUT (MEM_TIMEOUT=0,
// TRAP_HALT=1) gets a directed halt / no-timeout sequence.
module tb_multicycle_controller;

  localparam int TMO = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       asrc;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       ala;
    logic       alb;
    logic       rfw;
    logic [1:0] rds;
    logic       done;
    logic       trap;
    logic       busy;
  } outv_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       tkn;
    logic [6:0] opc;
    outv_t      exp;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Vectoring DUT signals
  logic       m_rst, m_rdy, m_tkn;
  logic [6:0] m_opc;
  logic       m_req, m_we, m_asrc, m_irw, m_pcw, m_ala, m_alb, m_rfw, m_done, m_trap, m_busy;
  logic [1:0] m_pcs, m_rds;
  outv_t      obs_m;

  // Halting DUT signals
  logic       h_rst, h_rdy, h_tkn;
  logic [6:0] h_opc;
  logic       h_req, h_we, h_asrc, h_irw, h_pcw, h_ala, h_alb, h_rfw, h_done, h_trap, h_busy;
  logic [1:0] h_pcs, h_rds;
  outv_t      obs_h;

  assign obs_m = {m_req, m_we, m_asrc, m_irw, m_pcw, m_pcs, m_ala, m_alb, m_rfw, m_rds, m_done, m_trap, m_busy};
  assign obs_h = {h_req, h_we, h_asrc, h_irw, h_pcw, h_pcs, h_ala, h_alb, h_rfw, h_rds, h_done, h_trap, h_busy};

  multicycle_controller #(.MEM_TIMEOUT(TMO), .TRAP_HALT(1'b0)) u_dut (
    .clk_i(clk), .rst_i(m_rst), .op_code_i(m_opc), .mem_ready_i(m_rdy), .branch_taken_i(m_tkn),
    .mem_req_o(m_req), .mem_we_o(m_we), .mem_addr_src_o(m_asrc), .ir_wr_en_o(m_irw),
    .pc_wr_en_o(m_pcw), .pc_src_o(m_pcs), .alu_src_a_o(m_ala), .alu_src_b_o(m_alb),
    .regf_wr_en_o(m_rfw), .regf_rd_src_o(m_rds), .instr_done_o(m_done), .trap_o(m_trap),
    .busy_o(m_busy)
  );

  multicycle_controller #(.MEM_TIMEOUT(0), .TRAP_HALT(1'b1)) u_halt (
    .clk_i(clk), .rst_i(h_rst), .op_code_i(h_opc), .mem_ready_i(h_rdy), .branch_taken_i(h_tkn),
    .mem_req_o(h_req), .mem_we_o(h_we), .mem_addr_src_o(h_asrc), .ir_wr_en_o(h_irw),
    .pc_wr_en_o(h_pcw), .pc_src_o(h_pcs), .alu_src_a_o(h_ala), .alu_src_b_o(h_alb),
    .regf_wr_en_o(h_rfw), .regf_rd_src_o(h_rds), .instr_done_o(h_done), .trap_o(h_trap),
    .busy_o(h_busy)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t sched[$];
  logic [6:0] legal_ops [9] = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    bit r = 1'b0;
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) r = 1'b1;
    return r;
  endfunction

  // A cycle whose inputs are don't-care noise and whose expected outputs are all zero.
  function automatic ent_t blank();
    ent_t e;
    e     = '0;
    e.rdy = 1'($urandom);
    e.tkn = 1'($urandom);
    e.opc = 7'($urandom);
    return e;
  endfunction

  function automatic ent_t trap_ent();
    ent_t e;
    e          = blank();
    e.exp.trap = 1'b1;
    e.exp.pcw  = 1'b1;
    e.exp.pcs  = 2'b11;
    e.exp.busy = 1'b1;
    return e;
  endfunction

  // Expand one instruction into its cycle-by-cycle schedule.
  // wf/wm: wait cycles before ready in fetch/mem; rst_at: cycle index to reset on (-1 none).
  task automatic gen(input logic [6:0] op, input int wf, input int wm, input bit tk, input int rst_at);
    ent_t q[$];
    ent_t e;
    bit   fin = 1'b0;
    bit   is_mem = (op == OP_LOAD) || (op == OP_STORE);
    for (int i = 0; i < wf && i < TMO; i++) begin
      e = blank(); e.rdy = 1'b0; e.exp.req = 1'b1; e.exp.busy = 1'b1; q.push_back(e);
    end
    if (wf >= TMO) begin
      q.push_back(trap_ent()); fin = 1'b1;
    end else begin
      e = blank(); e.rdy = 1'b1; e.exp.req = 1'b1; e.exp.irw = 1'b1; e.exp.busy = 1'b1; q.push_back(e);
    end
    if (!fin) begin
      e = blank(); e.opc = op; e.exp.busy = 1'b1; q.push_back(e);
      if (!legal(op)) begin q.push_back(trap_ent()); fin = 1'b1; end
    end
    if (!fin) begin
      e = blank(); e.exp.busy = 1'b1;
      e.exp.ala = (op == OP_AUIPC) || (op == OP_JAL);
      e.exp.alb = (op inside {OP_IALU, OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC, OP_JAL});
      if (op == OP_BRANCH) begin
        e.tkn = tk; e.exp.pcw = 1'b1; e.exp.pcs = {1'b0, tk}; e.exp.done = 1'b1; fin = 1'b1;
      end
      q.push_back(e);
    end
    if (!fin && is_mem) begin
      for (int i = 0; i < wm && i < TMO; i++) begin
        e = blank(); e.rdy = 1'b0; e.exp.req = 1'b1; e.exp.asrc = 1'b1;
        e.exp.we = (op == OP_STORE); e.exp.busy = 1'b1; q.push_back(e);
      end
      if (wm >= TMO) begin
        q.push_back(trap_ent()); fin = 1'b1;
      end else begin
        e = blank(); e.rdy = 1'b1; e.exp.req = 1'b1; e.exp.asrc = 1'b1;
        e.exp.we = (op == OP_STORE); e.exp.busy = 1'b1;
        if (op == OP_STORE) begin e.exp.pcw = 1'b1; e.exp.done = 1'b1; fin = 1'b1; end
        q.push_back(e);
      end
    end
    if (!fin) begin
      e = blank(); e.exp.busy = 1'b1; e.exp.rfw = 1'b1; e.exp.pcw = 1'b1; e.exp.done = 1'b1;
      e.exp.pcs = (op == OP_JAL) ? 2'b01 : (op == OP_JALR) ? 2'b10 : 2'b00;
      e.exp.rds = (op == OP_LOAD) ? 2'b01 : ((op == OP_JAL) || (op == OP_JALR)) ? 2'b10 :
                  (op == OP_LUI) ? 2'b11 : 2'b00;
      q.push_back(e);
    end
    if (rst_at >= 0 && rst_at < q.size()) begin
      while (q.size() > rst_at + 1) void'(q.pop_back());
      e = q[rst_at]; e.rst = 1'b1; q[rst_at] = e;
      q.push_back(blank());   // IDLE cycle after reset
    end
    foreach (q[i]) sched.push_back(q[i]);
  endtask

  outv_t ex;

  initial begin
    m_rst = 1'b1; m_rdy = 1'b0; m_tkn = 1'b0; m_opc = 7'd0;
    h_rst = 1'b1; h_rdy = 1'b0; h_tkn = 1'b0; h_opc = 7'd0;

    // Build the schedule: IDLE after reset, directed cases, then random traffic.
    sched.push_back(blank());
    gen(OP_R,      0, 0, 1'b0, -1);   // ADD zero-wait
    gen(OP_LOAD,   2, 2, 1'b0, -1);   // LW, 3-cycle request in fetch and mem
    gen(OP_BRANCH, 0, 0, 1'b1, -1);   // BEQ taken
    gen(OP_BRANCH, 0, 0, 1'b0, -1);   // BEQ not taken
    gen(7'b0000000, 0, 0, 1'b0, -1);  // illegal opcode
    gen(OP_STORE,  0, 6, 1'b0, -1);   // SW, ready never comes -> timeout
    gen(OP_STORE,  0, 3, 1'b0, -1);   // SW, ready on 4th wait cycle wins
    gen(OP_STORE,  0, 1, 1'b0, 3);    // SW, reset in first MEM cycle
    gen(OP_R,      4, 0, 1'b0, -1);   // fetch timeout
    gen(OP_JAL,    0, 0, 1'b0, -1);
    gen(OP_JALR,   1, 0, 1'b0, -1);
    gen(OP_LUI,    0, 0, 1'b0, -1);
    gen(OP_AUIPC,  0, 0, 1'b0, -1);
    gen(OP_IALU,   0, 0, 1'b0, -1);
    for (int n = 0; n < 200; n++) begin
      logic [6:0] op;
      int wf, wm, ra;
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
      wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
      wm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 8)) : -1;
      gen(op, wf, wm, 1'($urandom), ra);
    end

    // Reset state of the vectoring DUT
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", obs_m, 32'd0);

    // Replay the schedule
    foreach (sched[i]) begin
      @(posedge clk);
      #1;
      m_rst = sched[i].rst;
      m_rdy = sched[i].rdy;
      m_tkn = sched[i].tkn;
      m_opc = sched[i].opc;
      @(negedge clk);
      check("cycle", obs_m, sched[i].exp);
      if (m_rfw && m_we) check("rfw_we_excl", 32'd1, 32'd0);
    end

    // Halting DUT: reset state and IDLE
    @(negedge clk);
    check("h_reset", obs_h, 32'd0);
    @(posedge clk); #1; h_rst = 1'b0;
    @(negedge clk);
    check("h_idle", obs_h, 32'd0);
    // Long fetch wait never times out with MEM_TIMEOUT=0
    ex = '0; ex.req = 1'b1; ex.busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; h_rdy = 1'b0;
      @(negedge clk);
      check("h_fetch_wait", obs_h, ex);
    end
    @(posedge clk); #1; h_rdy = 1'b1;
    @(negedge clk);
    ex.irw = 1'b1;
    check("h_fetch_rdy", obs_h, ex);
    @(posedge clk); #1; h_rdy = 1'b0; h_opc = 7'b0000000;
    @(negedge clk);
    ex = '0; ex.busy = 1'b1;
    check("h_decode", obs_h, ex);
    // Terminal trap: trap_o held, not busy, no PC redirect, ready ignored
    ex = '0; ex.trap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; h_rdy = 1'($urandom); h_opc = 7'($urandom);
      @(negedge clk);
      check("h_trap_hold", obs_h, ex);
    end
    @(posedge clk); #1; h_rst = 1'b1;
    @(posedge clk); #1; h_rst = 1'b0;
    @(negedge clk);
    check("h_trap_reset", obs_h, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    ex = '0; ex.req = 1'b1; ex.busy = 1'b1; ex.irw = h_rdy;
    check("h_refetch", obs_h, ex);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
